top_design: RTL and testbench
=============================

TOP_DESIGN -- requirements
Module: top_design

Interface
REQ-001 Parameter CNT_WIDTH, default 12: refresh-counter width; each digit is displayed for 2^(CNT_WIDTH-2) clock cycles; legal range 3..32.
REQ-002 i_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 i_rst  input  1  synchronous, active-high reset, sampled on i_clk rising edge.
REQ-004 data_in  input  16  four hex nibbles to display: [3:0] digit0, [7:4] digit1, [11:8] digit2, [15:12] digit3.
REQ-005 an_seg  output  4  digit anode enables, active-low, one-hot-low while running; bit k enables digit k, with bit 0 the rightmost digit.
REQ-006 Sseg_out  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a} (bit 0 = a).
REQ-007 The block SHALL have exactly one clock (i_clk), and reset SHALL be synchronous and active-high (i_rst).

Function
REQ-008 The block SHALL contain a free-running CNT_WIDTH-bit up-counter that increments by 1 every cycle and wraps from all-ones to 0.
REQ-009 The digit select SHALL be counter bits [CNT_WIDTH-1:CNT_WIDTH-2]: 0 selects digit0, 1 digit1, 2 digit2, 3 digit3.
REQ-010 For select k, an_seg SHALL be all ones except bit k = 0 (k=0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111).
REQ-011 Sseg_out SHALL be the active-low hex decode of the selected nibble: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-012 an_seg and Sseg_out SHALL be registered, so both update on the same edge, one cycle after the counter reaches the corresponding value; an_seg and Sseg_out SHALL never show a mismatched digit and segment pattern.
REQ-013 data_in SHALL NOT be latched; a change in data_in SHALL appear on Sseg_out one cycle later whenever the changed nibble is selected.
REQ-014 Full scan period SHALL be 2^CNT_WIDTH cycles (default 4096); digit order SHALL be 0,1,2,3 and repeat.
REQ-015 Counter wrap SHALL be seamless: digit3 is followed directly by digit0 with no blank cycle.

Reset
REQ-016 While i_rst=1 at a rising edge, the counter SHALL load 0, an_seg SHALL load 1111 (all digits off), and Sseg_out SHALL load 1111111 (blank).
REQ-017 On the first edge after i_rst deasserts, outputs SHALL show digit0 (an_seg=1110) with the decode of data_in[3:0].
REQ-018 A reset asserted mid-scan SHALL override counting on that edge and restart at digit0.
REQ-019 Output state before the first reset edge is undefined; no initial values SHALL be relied on.

Verification
REQ-020 Reset with default CNT_WIDTH and data_in=16'h0146, then release -> digit0 (an_seg=1110) shows 6 (0000010) for 1024 cycles, then digit1 (1101) shows 4 (0011001), then digit2 (1011) shows 1 (1111001), then digit3 (0111) shows 0 (1000000).
REQ-021 Hold i_rst=1 for 5 cycles -> an_seg=1111 and Sseg_out=1111111 on every one of those cycles; assert i_rst mid-digit2 -> next edge blank, first edge after release shows digit0.
REQ-022 Sweep all 16 nibble values on data_in[3:0] while digit0 is selected -> Sseg_out matches the REQ-011 table each cycle, one cycle after each change.
REQ-023 Apply 16'hA967, then 16'hF178, changing data_in every 5000 cycles -> each 4096-cycle scan shows all four nibbles of the current word; after a mid-scan change, a later digit shows its new value when next selected.
REQ-024 Monitor for 3 full scans -> exactly one an_seg bit is low on every post-reset cycle, digit dwell is exactly 1024 cycles, and there is no gap at counter wrap.
REQ-025 Set CNT_WIDTH=4 -> dwell is 4 cycles per digit and the full scan is 16 cycles.

Source files
------------

// File: rtl/top_design.sv
// rtl/top_design.sv - four-digit multiplexed seven-segment hex display driver
// A free-running counter scans the digits; anode and segment outputs are registered together.
module top_design #(
    parameter int CNT_WIDTH = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] data_in,
    output logic [3:0]  an_seg,
    output logic [6:0]  Sseg_out
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [3:0]           an_q;
    logic [3:0]           an_d;
    logic [6:0]           sseg_q;
    logic [6:0]           sseg_d;
    logic [1:0]           sel;
    logic [3:0]           nibble;

    always_comb begin
        sel    = cnt_q[CNT_WIDTH-1 -: 2];
        cnt_d  = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        an_d   = 4'b1111;
        nibble = data_in[3:0];
        case (sel)
            2'd0: begin an_d = 4'b1110; nibble = data_in[3:0];   end
            2'd1: begin an_d = 4'b1101; nibble = data_in[7:4];   end
            2'd2: begin an_d = 4'b1011; nibble = data_in[11:8];  end
            default: begin an_d = 4'b0111; nibble = data_in[15:12]; end
        endcase
    end

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    always_comb begin
        sseg_d = 7'b1111111;
        case (nibble)
            4'h0: sseg_d = 7'b1000000;
            4'h1: sseg_d = 7'b1111001;
            4'h2: sseg_d = 7'b0100100;
            4'h3: sseg_d = 7'b0110000;
            4'h4: sseg_d = 7'b0011001;
            4'h5: sseg_d = 7'b0010010;
            4'h6: sseg_d = 7'b0000010;
            4'h7: sseg_d = 7'b1111000;
            4'h8: sseg_d = 7'b0000000;
            4'h9: sseg_d = 7'b0010000;
            4'hA: sseg_d = 7'b0001000;
            4'hB: sseg_d = 7'b0000011;
            4'hC: sseg_d = 7'b1000110;
            4'hD: sseg_d = 7'b0100001;
            4'hE: sseg_d = 7'b0000110;
            default: sseg_d = 7'b0001110;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            an_q   <= 4'b1111;
            sseg_q <= 7'b1111111;
        end else begin
            cnt_q  <= cnt_d;
            an_q   <= an_d;
            sseg_q <= sseg_d;
        end
    end

    assign an_seg   = an_q;
    assign Sseg_out = sseg_q;

endmodule

// File: tb/tb_top_design.sv
// tb/tb_top_design.sv - scoreboard bench for top_design at default width and CNT_WIDTH=4
module tb_top_design;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic [3:0]  an_seg;
    logic [6:0]  Sseg_out;
    logic [3:0]  an4;
    logic [6:0]  sseg4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 i_clk = ~i_clk;

    top_design dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .data_in (data_in),
        .an_seg  (an_seg),
        .Sseg_out(Sseg_out)
    );

    top_design #(.CNT_WIDTH(4)) dut4 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .data_in (data_in),
        .an_seg  (an4),
        .Sseg_out(sseg4)
    );

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [10:0] q_main  [$];
    logic [10:0] q_small [$];
    logic [11:0] m_cnt  = '0;
    logic [3:0]  m_cnt4 = '0;

    // Reference model: expected outputs for each edge, pushed as the edge happens
    always @(posedge i_clk) begin
        if (i_rst) begin
            q_main.push_back({4'hF, 7'h7F});
            q_small.push_back({4'hF, 7'h7F});
            m_cnt  = '0;
            m_cnt4 = '0;
        end else begin
            q_main.push_back({~(4'b0001 << m_cnt[11:10]), SEG_TAB[data_in[4*m_cnt[11:10] +: 4]]});
            q_small.push_back({~(4'b0001 << m_cnt4[3:2]), SEG_TAB[data_in[4*m_cnt4[3:2] +: 4]]});
            m_cnt  = m_cnt + 12'd1;
            m_cnt4 = m_cnt4 + 4'd1;
        end
    end

    logic [3:0] got_an, got_an4, exp_an, exp_an4;
    logic [6:0] got_seg, got_seg4, exp_seg, exp_seg4;

    task automatic step();
        @(posedge i_clk);
        #1;
        got_an   = an_seg;
        got_seg  = Sseg_out;
        got_an4  = an4;
        got_seg4 = sseg4;
        if (q_main.size() > 0) {exp_an, exp_seg} = q_main.pop_front();
        else {exp_an, exp_seg} = 'x;
        if (q_small.size() > 0) {exp_an4, exp_seg4} = q_small.pop_front();
        else {exp_an4, exp_seg4} = 'x;
    endtask

    task automatic test_reset();
        data_in = 16'h0146;
        i_rst   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total_cnt++;
            if (got_an !== 4'b1111 || got_seg !== 7'b1111111)
                $display("FAIL reset_hold cyc=%0d an=%b seg=%b want an=1111 seg=1111111", i, got_an, got_seg);
            else pass_cnt++;
        end
        i_rst = 1'b0;
        step();
        total_cnt++;
        if (got_an !== 4'b1110 || got_seg !== 7'b0000010)
            $display("FAIL reset_release an=%b seg=%b want an=1110 seg=0000010", got_an, got_seg);
        else pass_cnt++;
    endtask

    task automatic test_digits();
        logic [3:0] want_an;
        logic [6:0] want_seg;
        for (int i = 1; i <= 4096; i++) begin
            step();
            total_cnt++;
            if ({got_an, got_seg} !== {exp_an, exp_seg})
                $display("FAIL digits_sb cyc=%0d an=%b seg=%b want an=%b seg=%b", i, got_an, got_seg, exp_an, exp_seg);
            else pass_cnt++;
            if (i == 1023 || i == 1024 || i == 2048 || i == 3072 || i == 4095 || i == 4096) begin
                case ((i / 1024) % 4)
                    0: begin want_an = 4'b1110; want_seg = 7'b0000010; end
                    1: begin want_an = 4'b1101; want_seg = 7'b0011001; end
                    2: begin want_an = 4'b1011; want_seg = 7'b1111001; end
                    default: begin want_an = 4'b0111; want_seg = 7'b1000000; end
                endcase
                total_cnt++;
                if (got_an !== want_an || got_seg !== want_seg)
                    $display("FAIL digits_fixed cyc=%0d an=%b seg=%b want an=%b seg=%b", i, got_an, got_seg, want_an, want_seg);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_sweep();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        for (int v = 0; v < 16; v++) begin
            data_in = {12'h5A3, v[3:0]};
            step();
            total_cnt++;
            if (got_an !== 4'b1110 || got_seg !== SEG_TAB[v])
                $display("FAIL sweep v=%0d an=%b seg=%b want an=1110 seg=%b", v, got_an, got_seg, SEG_TAB[v]);
            else pass_cnt++;
            total_cnt++;
            if ({got_an, got_seg} !== {exp_an, exp_seg})
                $display("FAIL sweep_sb v=%0d an=%b seg=%b want an=%b seg=%b", v, got_an, got_seg, exp_an, exp_seg);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        data_in = 16'h0146;
        i_rst   = 1'b1;
        step();
        i_rst = 1'b0;
        for (int i = 0; i < 2100; i++) step();
        total_cnt++;
        if (got_an !== 4'b1011 || got_seg !== 7'b1111001)
            $display("FAIL mid_pre an=%b seg=%b want an=1011 seg=1111001", got_an, got_seg);
        else pass_cnt++;
        i_rst = 1'b1;
        step();
        total_cnt++;
        if (got_an !== 4'b1111 || got_seg !== 7'b1111111)
            $display("FAIL mid_blank an=%b seg=%b want an=1111 seg=1111111", got_an, got_seg);
        else pass_cnt++;
        i_rst = 1'b0;
        step();
        total_cnt++;
        if (got_an !== 4'b1110 || got_seg !== 7'b0000010)
            $display("FAIL mid_restart an=%b seg=%b want an=1110 seg=0000010", got_an, got_seg);
        else pass_cnt++;
    endtask

    task automatic test_words();
        data_in = 16'hA967;
        i_rst   = 1'b1;
        step();
        i_rst = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (c == 5000) data_in = 16'hF178;
            step();
            total_cnt++;
            if ({got_an, got_seg} !== {exp_an, exp_seg})
                $display("FAIL words_sb cyc=%0d an=%b seg=%b want an=%b seg=%b", c, got_an, got_seg, exp_an, exp_seg);
            else pass_cnt++;
        end
    endtask

    task automatic test_scan();
        logic [3:0] prev_an;
        int run;
        int changes;
        data_in = 16'h3C8E;
        i_rst   = 1'b1;
        step();
        i_rst = 1'b0;
        step();
        prev_an = got_an;
        run     = 1;
        changes = 0;
        for (int i = 1; i < 3 * 4096; i++) begin
            step();
            total_cnt++;
            if ($countones(~got_an) != 1)
                $display("FAIL scan_onehot cyc=%0d an=%b want exactly one low bit", i, got_an);
            else pass_cnt++;
            if (got_an != prev_an) begin
                changes++;
                total_cnt++;
                if (run != 1024)
                    $display("FAIL scan_dwell cyc=%0d dwell=%0d want 1024", i, run);
                else pass_cnt++;
                run = 1;
            end else run++;
            prev_an = got_an;
        end
        total_cnt++;
        if (changes != 11)
            $display("FAIL scan_changes got=%0d want 11", changes);
        else pass_cnt++;
    endtask

    task automatic test_small();
        logic [3:0] prev_an;
        int run;
        data_in = 16'hB2D9;
        i_rst   = 1'b1;
        step();
        i_rst = 1'b0;
        step();
        prev_an = got_an4;
        run     = 1;
        total_cnt++;
        if (got_an4 !== 4'b1110 || got_seg4 !== 7'b0010000)
            $display("FAIL small_first an=%b seg=%b want an=1110 seg=0010000", got_an4, got_seg4);
        else pass_cnt++;
        for (int i = 1; i < 40; i++) begin
            step();
            total_cnt++;
            if ({got_an4, got_seg4} !== {exp_an4, exp_seg4})
                $display("FAIL small_sb cyc=%0d an=%b seg=%b want an=%b seg=%b", i, got_an4, got_seg4, exp_an4, exp_seg4);
            else pass_cnt++;
            if (got_an4 != prev_an) begin
                total_cnt++;
                if (run != 4)
                    $display("FAIL small_dwell cyc=%0d dwell=%0d want 4", i, run);
                else pass_cnt++;
                run = 1;
            end else run++;
            prev_an = got_an4;
        end
        total_cnt++;
        if (got_an4 !== 4'b1101)
            $display("FAIL small_scan_wrap an=%b want 1101", got_an4);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_digits();
        test_sweep();
        test_mid_reset();
        test_words();
        test_scan();
        test_small();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
